pb_layer_sequencer: RTL

Multi-cycle controller that runs the 16-PB processing array through successive network layers.
- Selects the per-layer weight/bias slice.
- Pulses the PBs to start and waits until every PB reports valid.
- Captures the array output into the X register bank and feeds it back as the next layer's input.
- Signals completion after the configured layer count.
- Sits between the top-level host interface and the PB array/X register bank, replacing combinational layer iteration.

---
 rtl/pb_layer_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pb_layer_sequencer.sv
// Layer sequencer for the PB processing array: steps weight/bias slices, starts the PBs,
// joins their valid flags and feeds captured X back. Optional watchdog: PB_WATCHDOG_EN.
module pb_layer_sequencer #(
    parameter int unsigned NUM_PB     = 16,
    parameter int unsigned MAX_LAYERS = 2,
    parameter int unsigned LW         = $clog2(MAX_LAYERS + 1),
    parameter int unsigned WDT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LW-1:0]     num_layers_cfg,
    input  logic [NUM_PB-1:0] pb_valid,
    output logic              pb_start,
    output logic [LW-1:0]     layer_idx,
    output logic              x_sel,
    output logic              capture_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t        state;
    logic [LW-1:0] n_lat;
    logic [LW-1:0] n_clamp_c;
    logic          all_valid_c;

    if (WDT_CYCLES == 0) begin : g_bad_wdt
        $error("WDT_CYCLES must be nonzero");
    end

    assign all_valid_c = &pb_valid;
    assign n_clamp_c   = (num_layers_cfg > LW'(MAX_LAYERS)) ? LW'(MAX_LAYERS) : num_layers_cfg;

`ifdef PB_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(WDT_CYCLES + 1);
    logic [WDW-1:0] wdt_cnt;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            n_lat      <= '0;
            layer_idx  <= '0;
            x_sel      <= 1'b0;
            pb_start   <= 1'b0;
            capture_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PB_WATCHDOG_EN
            wdt_cnt    <= '0;
            error      <= 1'b0;
`endif
        end else begin
            pb_start   <= 1'b0;
            capture_en <= 1'b0;
            done       <= 1'b0;
            // Abort beats every other transition, including the all-valid exit.
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            n_lat     <= n_clamp_c;
                            layer_idx <= '0;
                            x_sel     <= 1'b0;
                            busy      <= 1'b1;
`ifdef PB_WATCHDOG_EN
                            error     <= 1'b0;
`endif
                            if (n_clamp_c == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        state    <= RUN;
                        pb_start <= 1'b1;
                    end
                    RUN: begin
                        state <= WAIT;
`ifdef PB_WATCHDOG_EN
                        wdt_cnt <= '0;
`endif
                    end
                    WAIT: begin
                        if (all_valid_c) begin
                            state      <= CAPTURE;
                            capture_en <= 1'b1;
`ifdef PB_WATCHDOG_EN
                        end else if (wdt_cnt == WDW'(WDT_CYCLES - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            wdt_cnt <= wdt_cnt + WDW'(1);
`endif
                        end
                    end
                    CAPTURE: begin
                        if (layer_idx == (n_lat - LW'(1))) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            layer_idx <= layer_idx + LW'(1);
                            x_sel     <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
